// File: rtl/integer_multiplication_controller.sv
// Multiply sequencer: sign handling, fixed-latency wait, result handshake.
// Optional last-product cache enabled by defining MUL_RESULT_CACHE_EN.
module integer_multiplication_controller #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic [31:0] mul_op1_o,
  output logic [31:0] mul_op2_o,
  input  logic [63:0] mul_result_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b00;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  op_q;
  logic        neg_q;
  logic        valid_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;

  logic        s1;
  logic        s2;
  logic        n1;
  logic        n2;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic        accept;
  logic        sample;
  logic [63:0] prod;
  logic [31:0] half;
  logic        hit;
  logic [63:0] hit_prod;
  logic [31:0] hit_half;

  // Operand signedness and magnitudes for the unsigned multiplier
  always_comb begin
    s1 = 1'b0;
    s2 = 1'b0;
    unique case (1'b1)
      (op_i == 2'b11): begin s1 = 1'b0; s2 = 1'b0; end
      (op_i == 2'b10): begin s1 = 1'b1; s2 = 1'b0; end
      default:         begin s1 = 1'b1; s2 = 1'b1; end
    endcase
    n1   = s1 & rs1_i[31];
    n2   = s2 & rs2_i[31];
    mag1 = n1 ? (~rs1_i + 32'd1) : rs1_i;
    mag2 = n2 ? (~rs2_i + 32'd1) : rs2_i;
  end

  assign ready_o = (state_q == IDLE) & ~flush_i & ~rst_i;
  assign accept  = valid_i & ready_o;
  assign sample  = (state_q == CALC) & (cnt_q == 4'd1);
  assign busy_o  = (state_q != IDLE);

  // Restore the sign of the product; zero negates to zero
  assign prod = neg_q ? (~mul_result_i + 64'd1) : mul_result_i;
  assign half = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];

`ifdef MUL_RESULT_CACHE_EN
  logic        c_vld_q;
  logic [63:0] c_prod_q;
  logic [31:0] c_rs1_q;
  logic [31:0] c_rs2_q;
  logic [1:0]  c_cls_q;
  logic [31:0] p_rs1_q;
  logic [31:0] p_rs2_q;
  logic [1:0]  p_cls_q;

  assign hit = c_vld_q & (c_rs1_q == rs1_i) & (c_rs2_q == rs2_i)
             & (c_cls_q == {s1, s2});
  assign hit_prod = c_prod_q;

  // Remember the last completed signed product and its key
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      c_vld_q  <= 1'b0;
      c_prod_q <= '0;
      c_rs1_q  <= '0;
      c_rs2_q  <= '0;
      c_cls_q  <= '0;
      p_rs1_q  <= '0;
      p_rs2_q  <= '0;
      p_cls_q  <= '0;
    end else if (accept && !hit) begin
      p_rs1_q <= rs1_i;
      p_rs2_q <= rs2_i;
      p_cls_q <= {s1, s2};
    end else if (sample) begin
      c_vld_q  <= 1'b1;
      c_prod_q <= prod;
      c_rs1_q  <= p_rs1_q;
      c_rs2_q  <= p_rs2_q;
      c_cls_q  <= p_cls_q;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_prod = 64'd0;
`endif

  assign hit_half = (op_i == OP_MUL) ? hit_prod[31:0] : hit_prod[63:32];

  // Main sequencer with registered handshake and multiplier outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= op_i;
            rd_q  <= rd_i;
            neg_q <= n1 ^ n2;
            if (hit) begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              result_q <= hit_half;
            end else begin
              state_q <= CALC;
              cnt_q   <= 4'(LATENCY);
              op1_q   <= mag1;
              op2_q   <= mag2;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= DONE;
            valid_q  <= 1'b1;
            result_q <= half;
            op1_q    <= '0;
            op2_q    <= '0;
          end
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign rd_o      = rd_q;
  assign mul_op1_o = op1_q;
  assign mul_op2_o = op2_q;

endmodule

// File: tb/tb_integer_multiplication_controller.sv
// Scoreboard bench for the multiply controller.
// Stimulus pushes expectations; a negedge monitor checks results.
module tb_integer_multiplication_controller;

  localparam int LAT = 2;
`ifdef MUL_RESULT_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = LAT + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  op_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] mul_op1;
  logic [31:0] mul_op2;
  logic [63:0] mul_result;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        busy_o;

  always #5 clk = ~clk;

  // Behavioural 32x32->64 unsigned multiplier
  assign mul_result = 64'(mul_op1) * 64'(mul_op2);

  integer_multiplication_controller #(.LATENCY(LAT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .op_i(op_i),
    .rs1_i(rs1_i),
    .rs2_i(rs2_i),
    .rd_i(rd_i),
    .flush_i(flush_i),
    .mul_op1_o(mul_op1),
    .mul_op2_o(mul_op2),
    .mul_result_i(mul_result),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .result_o(result_o),
    .rd_o(rd_o),
    .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   seen = 0;
  bit   mute = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_hi(input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return p[63:32];
  endfunction

  // Monitor: latency on first valid cycle, data every valid cycle
  always @(negedge clk) begin
    if (!rst && !mute && valid_o) begin
      if (sbq.size() == 0) begin
        chk("spurious_valid", valid_o, 0);
      end else begin
        if (!seen) begin
          chk("latency", cyc - sbq[0].acc, sbq[0].lat);
          seen = 1;
        end
        chk("result", result_o, sbq[0].res);
        chk("rd", rd_o, sbq[0].rd);
        if (ready_i) begin
          chk("no_accept_at_handshake", ready_o, 0);
          void'(sbq.pop_front());
          seen = 0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int lat,
                       input bit push);
    int n = 0;
    valid_i = 1'b1;
    op_i = op;
    rs1_i = a;
    rs2_i = b;
    rd_i = rd;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      chk("accept_timeout", ready_o, 1);
    end else if (push) begin
      sbq.push_back('{exp, rd, cyc, lat});
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sbq.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_op1", mul_op1, 0);
    chk("rst_op2", mul_op2, 0);
    chk("rst_ready", ready_o, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", ready_o, 1);
    @(negedge clk);

    issue(2'b00, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, LAT + 1, 1);
    chk("calc_op1", mul_op1, 32'd7);
    chk("calc_op2", mul_op2, 32'd3);
    chk("calc_busy", busy_o, 1);
    drain();
    chk("idle_op1", mul_op1, 0);

    issue(2'b01, 32'h80000000, 32'h80000000, 5'd5, 32'h40000000, LAT + 1, 1);
    chk("min_mag", mul_op1, 32'h80000000);
    drain();
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, LAT + 1, 1);
    chk("mulhu_mag", mul_op1, 32'hFFFFFFFF);
    drain();
    issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFF, LAT + 1, 1);
    chk("mulhsu_op1", mul_op1, 32'd1);
    chk("mulhsu_op2", mul_op2, 32'hFFFFFFFF);
    drain();
    issue(2'b01, 32'hFFFFFFFF, 32'd0, 5'd8, 32'd0, LAT + 1, 1);
    drain();

    ready_i = 1'b0;
    issue(2'b00, 32'd6, 32'd7, 5'd9, 32'd42, LAT + 1, 1);
    n = 0;
    while (!valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", valid_o, 1);
    repeat (5) begin
      chk("stall_ready_o", ready_o, 0);
      @(negedge clk);
    end
    ready_i = 1'b1;
    drain();
    repeat (3) @(negedge clk);

    issue(2'b00, 32'd3, 32'd4, 5'd10, 32'd12, LAT + 1, 0);
    flush_i = 1'b1;
    #1;
    chk("flush_ready_o", ready_o, 0);
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 0);
    chk("flush_valid", valid_o, 0);
    repeat (5) @(negedge clk);
    issue(2'b00, 32'd5, 32'd5, 5'd11, 32'd25, LAT + 1, 1);
    drain();

    issue(2'b00, 32'd9, 32'd9, 5'd12, 32'd81, LAT + 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_calc_busy", busy_o, 0);
    repeat (5) @(negedge clk);

    mute = 1'b1;
    ready_i = 1'b0;
    issue(2'b00, 32'd2, 32'd8, 5'd13, 32'd16, LAT + 1, 0);
    n = 0;
    while (!valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_before_rst", valid_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready_i = 1'b1;
    mute = 1'b0;
    chk("rst_done_valid", valid_o, 0);
    chk("rst_done_busy", busy_o, 0);
    repeat (5) @(negedge clk);

    issue(2'b01, 32'h12345678, 32'h9ABCDEF0, 5'd1,
          ref_hi(32'h12345678, 32'h9ABCDEF0), LAT + 1, 1);
    drain();
    issue(2'b00, 32'h12345678, 32'h9ABCDEF0, 5'd2, 32'h242D2080,
          HIT_LAT, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/integer_multiplication_controller.md
INTEGER_MULTIPLICATION_CONTROLLER -- requirements
Module: integer_multiplication_controller

Interface
REQ-001 SHALL have parameter LATENCY, default 2, cycles from operand drive to sampling mul_result_i (legal range 1..15).
REQ-002 SHALL have port clk_i, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port valid_i, input, 1, request valid from execute issue.
REQ-005 SHALL have port ready_o, output, 1, controller can accept a request.
REQ-006 SHALL have port op_i, input, 2, 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 SHALL have ports rs1_i and rs2_i, input, 32 each, source operands.
REQ-008 SHALL have port rd_i, input, 5, destination tag, returned unchanged on rd_o.
REQ-009 SHALL have port flush_i, input, 1, kill in-flight operation.
REQ-010 SHALL have ports mul_op1_o and mul_op2_o, output, 32 each, unsigned magnitudes to the 32x32->64 multiplier.
REQ-011 SHALL have port mul_result_i, input, 64, unsigned product from the multiplier.
REQ-012 SHALL have ports valid_o, output, 1, and ready_i, input, 1, result handshake.
REQ-013 SHALL have ports result_o, output, 32, and rd_o, output, 5, result and tag.
REQ-014 SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 SHALL have ready_o = 1 only in IDLE with flush_i low; acceptance = valid_i & ready_o.
REQ-017 On acceptance SHALL latch op, rd, operand signs, and magnitudes; go to CALC with counter = LATENCY.
REQ-018 Signedness SHALL be: MUL/MULH both signed, MULHSU rs1 signed and rs2 unsigned, MULHU both unsigned.
REQ-019 Magnitude of a negative signed operand SHALL be its 32-bit two's complement; 0x80000000 yields 0x80000000.
REQ-020 mul_op1_o/mul_op2_o SHALL hold latched magnitudes stable throughout CALC; 0 in IDLE.
REQ-021 CALC SHALL decrement counter each cycle; at counter == 1 SHALL sample mul_result_i, negate 64-bit product if operand signs differ (zero stays zero), and go to DONE.
REQ-022 result_o SHALL be product[31:0] for MUL, product[63:32] otherwise.
REQ-023 valid_o SHALL assert in DONE; first valid cycle is LATENCY+1 edges after the acceptance edge.
REQ-024 result_o and rd_o SHALL stay stable while valid_o & !ready_i; DONE with ready_i high returns to IDLE next edge.
REQ-025 flush_i high in any state SHALL force IDLE next edge, drop valid_o, discard the result; flush_i has priority over valid_i and ready_i in the same cycle.
REQ-026 A new request SHALL NOT be accepted in the same cycle a result handshakes; earliest next acceptance is the following IDLE cycle.

Reset
REQ-027 rst_i SHALL force IDLE, counter 0, valid_o 0, busy_o 0, result_o 0, rd_o 0, mul_op1_o/mul_op2_o 0; ready_o becomes 1 the cycle after rst_i deasserts.
REQ-028 Reset mid-CALC or mid-DONE SHALL discard the operation with no valid_o pulse.

Configuration
REQ-029 With macro MUL_RESULT_CACHE_EN defined, SHALL keep the last completed signed 64-bit product with its rs1, rs2, and signedness class; an accepted request matching all three SHALL skip CALC, enter DONE next edge (valid_o one edge after acceptance), and select the half per REQ-022; flush_i and rst_i SHALL invalidate the cache.
REQ-030 Without MUL_RESULT_CACHE_EN, SHALL have no cache storage; every request SHALL take LATENCY+1 cycles.

Verification
REQ-031 MUL rs1=7, rs2=0xFFFFFFFD -> result_o 0xFFFFFFEB, valid_o at acceptance+LATENCY+1.
REQ-032 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF; MULH 0xFFFFFFFF x 0 -> 0x00000000.
REQ-034 ready_i held low 5 cycles during DONE -> result_o/rd_o stable, ready_o low, one handshake only.
REQ-035 flush_i pulse in CALC cycle 1 -> no valid_o, IDLE next edge, next request completes correctly.
REQ-036 With MUL_RESULT_CACHE_EN: MULH 0x12345678 x 0x9ABCDEF0 then MUL same operands -> second valid_o one edge after acceptance, result_o 0x242D2080; without macro -> LATENCY+1 edges.
